// File: rtl/scan_mux_if.sv
// Control/observation bundle of the scanning multiplexer.
// The master drives run/dir/load/data. The slave (the scanner) returns the registered outputs.
interface scan_mux_if #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic                run;
  logic                dir;
  logic                load;
  logic [SEL_W-1:0]    load_sel;
  logic [CHANNELS-1:0] data;
  logic                out;
  logic [SEL_W-1:0]    select;
  logic                tick;
  logic                wrap;
  logic                slow;

  modport master (
    output run, dir, load, load_sel, data,
    input  out, select, tick, wrap, slow
  );

  modport slave (
    input  run, dir, load, load_sel, data,
    output out, select, tick, wrap, slow
  );
endinterface

// File: rtl/scan_mux.sv
// N-channel scanning multiplexer. A prescaler enable tick steps a channel index up or down.
// Adds pause, direct load, a wrap pulse and a 50%-duty slow phase. All outputs are registered.
module scan_mux #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int RATE     = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic      clk,
  input  logic      clear,
  scan_mux_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic             SLOW_RST = (RATE >= 2) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_nxt_s;
  logic [SEL_W-1:0] sel_step_s;
  logic             out_r;
  logic             tick_r;
  logic             wrap_r;
  logic             slow_r;
  logic             tick_nxt_s;
  logic             wrap_nxt_s;
  logic             wrap_step_s;
  logic             slow_nxt_s;
  logic             load_ok_s;
  logic             at_end_s;

  // A load target outside the channel range is dropped; a full power-of-two range needs no check.
  generate
    if (CHANNELS == (2 ** SEL_W)) begin : g_load_full
      assign load_ok_s = bus.load;
    end else begin : g_load_chk
      localparam logic [SEL_W:0] CHAN_LIM = (SEL_W + 1)'(CHANNELS);
      assign load_ok_s = bus.load && ({1'b0, bus.load_sel} < CHAN_LIM);
    end
  endgenerate

  assign at_end_s = (cnt_r == CNT_LAST);

  // Neighbouring channel in the requested direction, with explicit wrap at both ends.
  always_comb begin
    sel_step_s  = sel_r;
    wrap_step_s = 1'b0;
    if (bus.dir) begin
      if (sel_r == {SEL_W{1'b0}}) begin
        sel_step_s  = SEL_LAST;
        wrap_step_s = 1'b1;
      end else begin
        sel_step_s  = sel_r - SEL_W'(1);
      end
    end else begin
      if (sel_r == SEL_LAST) begin
        sel_step_s  = {SEL_W{1'b0}};
        wrap_step_s = 1'b1;
      end else begin
        sel_step_s  = sel_r + SEL_W'(1);
      end
    end
  end

  // Next state: a valid load beats any step, and pause holds the count and the channel.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    sel_nxt_s  = sel_r;
    tick_nxt_s = 1'b0;
    wrap_nxt_s = 1'b0;
    if (load_ok_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      sel_nxt_s = bus.load_sel;
    end else if (bus.run) begin
      tick_nxt_s = at_end_s;
      if (at_end_s) begin
        cnt_nxt_s  = {CNT_W{1'b0}};
        sel_nxt_s  = sel_step_s;
        wrap_nxt_s = wrap_step_s;
      end else begin
        cnt_nxt_s  = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
      sel_nxt_s = sel_r;
    end
  end

  // slow mirrors the count that will be held after the edge. With RATE=1 it is always low.
  generate
    if (RATE >= 2) begin : g_slow
      localparam logic [CNT_W-1:0] HALF = CNT_W'(RATE / 2);
      assign slow_nxt_s = (cnt_nxt_s < HALF);
    end else begin : g_no_slow
      assign slow_nxt_s = 1'b0;
    end
  endgenerate

  // State and registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_r  <= {CNT_W{1'b0}};
      sel_r  <= {SEL_W{1'b0}};
      out_r  <= 1'b0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
      slow_r <= SLOW_RST;
    end else begin
      cnt_r  <= cnt_nxt_s;
      sel_r  <= sel_nxt_s;
      out_r  <= bus.data[sel_r];
      tick_r <= tick_nxt_s;
      wrap_r <= wrap_nxt_s;
      slow_r <= slow_nxt_s;
    end
  end

  assign bus.out    = out_r;
  assign bus.select = sel_r;
  assign bus.tick   = tick_r;
  assign bus.wrap   = wrap_r;
  assign bus.slow   = slow_r;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: a 5-channel RATE=4 scanner and an 8-channel RATE=1 scanner, both checked
// against an integer reference model through directed steps and a randomized phase.
module tb_scan_mux;

  logic clk = 1'b0;
  logic clear_a;
  logic clear_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scan_mux_if #(.CHANNELS(5), .SEL_W(3)) ia ();
  scan_mux_if #(.CHANNELS(8), .SEL_W(3)) ib ();

  scan_mux #(.CHANNELS(5), .SEL_W(3), .RATE(4), .CNT_W(2)) dut_a (
    .clk(clk), .clear(clear_a), .bus(ia.slave)
  );
  scan_mux #(.CHANNELS(8), .SEL_W(3), .RATE(1), .CNT_W(1)) dut_b (
    .clk(clk), .clear(clear_b), .bus(ib.slave)
  );

  // Reference model state: index 0 is dut_a, index 1 is dut_b.
  int CH [2] = '{5, 8};
  int RT [2] = '{4, 1};
  int m_cnt [2];
  int m_sel [2];
  bit m_tick [2];
  bit m_wrap [2];
  bit m_out [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_slow(int k);
    return (RT[k] >= 2) && (m_cnt[k] < RT[k] / 2);
  endfunction

  task automatic model_reset(int k);
    m_cnt[k] = 0; m_sel[k] = 0; m_tick[k] = 0; m_wrap[k] = 0; m_out[k] = 0;
  endtask

  task automatic model_update(int k, bit run, bit dir, bit load, int lsel, logic [7:0] data);
    m_out[k] = data[m_sel[k]];
    if (load && lsel < CH[k]) begin
      m_sel[k] = lsel; m_cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (run) begin
      m_tick[k] = (m_cnt[k] == RT[k] - 1);
      m_wrap[k] = 0;
      if (m_tick[k]) begin
        if (!dir) begin
          m_wrap[k] = (m_sel[k] == CH[k] - 1);
          m_sel[k]  = (m_sel[k] + 1) % CH[k];
        end else begin
          m_wrap[k] = (m_sel[k] == 0);
          m_sel[k]  = (m_sel[k] + CH[k] - 1) % CH[k];
        end
      end
      m_cnt[k] = (m_cnt[k] + 1) % RT[k];
    end else begin
      m_tick[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic check_all();
    check("a.select", 32'(ia.select), m_sel[0]);
    check("a.out",    32'(ia.out),    32'(m_out[0]));
    check("a.tick",   32'(ia.tick),   32'(m_tick[0]));
    check("a.wrap",   32'(ia.wrap),   32'(m_wrap[0]));
    check("a.slow",   32'(ia.slow),   32'(exp_slow(0)));
    check("b.select", 32'(ib.select), m_sel[1]);
    check("b.out",    32'(ib.out),    32'(m_out[1]));
    check("b.tick",   32'(ib.tick),   32'(m_tick[1]));
    check("b.wrap",   32'(ib.wrap),   32'(m_wrap[1]));
    check("b.slow",   32'(ib.slow),   32'(exp_slow(1)));
  endtask

  // One clock: latch the inputs applied before the edge, advance the model, check 1 time unit later.
  task automatic cycle();
    bit ra, da, la, rb, db, lb;
    int sa, sb;
    logic [7:0] dta, dtb;
    ra = ia.run; da = ia.dir; la = ia.load; sa = int'(ia.load_sel); dta = {3'b000, ia.data};
    rb = ib.run; db = ib.dir; lb = ib.load; sb = int'(ib.load_sel); dtb = ib.data;
    @(posedge clk);
    if (clear_a) model_reset(0); else model_update(0, ra, da, la, sa, dta);
    if (clear_b) model_reset(1); else model_update(1, rb, db, lb, sb, dtb);
    #1;
    check_all();
  endtask

  // Raise clear between edges, check the effect without a clock, hold through one edge, release between edges.
  task automatic async_clear(int k);
    #2;
    if (k == 0) clear_a = 1'b1; else clear_b = 1'b1;
    #1;
    model_reset(k);
    check_all();
    #2;
    cycle();
    #2;
    if (k == 0) clear_a = 1'b0; else clear_b = 1'b0;
  endtask

  initial begin
    int n_tick, n_wrap;
    clear_a = 1'b1; clear_b = 1'b1;
    ia.run = 1'b1; ia.dir = 1'b0; ia.load = 1'b0; ia.load_sel = 3'd0; ia.data = 5'b10110;
    ib.run = 1'b1; ib.dir = 1'b0; ib.load = 1'b0; ib.load_sel = 3'd0; ib.data = 8'($urandom);
    #1;
    model_reset(0); model_reset(1);
    check_all();
    check("rst.slow_a", 32'(ia.slow), 32'd1);
    check("rst.slow_b", 32'(ib.slow), 32'd0);
    #2;
    clear_a = 1'b0; clear_b = 1'b0;

    // Up-scan: 20 clocks give 5 ticks, and the one wrap comes on the 4->0 step.
    n_tick = 0; n_wrap = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_tick += int'(ia.tick);
      n_wrap += int'(ia.wrap);
      check("b.tick_const", 32'(ib.tick), 32'd1);
    end
    check("up.ticks", n_tick, 32'd5);
    check("up.wraps", n_wrap, 32'd1);
    check("up.sel_end", 32'(ia.select), 32'd0);

    // Down-scan from channel 0.
    ia.dir = 1'b1;
    repeat (4) cycle();
    check("down.first_sel", 32'(ia.select), 32'd4);
    check("down.first_wrap", 32'(ia.wrap), 32'd1);
    repeat (16) cycle();
    check("down.sel_end", 32'(ia.select), 32'd0);

    // Pause at prescaler=2 for 10 clocks, then the tick must come 2 running clocks later.
    repeat (2) cycle();
    ia.run = 1'b0;
    repeat (10) cycle();
    check("pause.sel", 32'(ia.select), 32'd0);
    check("pause.slow", 32'(ia.slow), 32'd0);
    ia.run = 1'b1;
    cycle();
    check("pause.no_tick", 32'(ia.tick), 32'd0);
    cycle();
    check("pause.tick", 32'(ia.tick), 32'd1);
    check("pause.sel_after", 32'(ia.select), 32'd4);

    // Load: valid load, then an out-of-range load, then a load on a tick cycle.
    ia.dir = 1'b0;
    ia.load = 1'b1; ia.load_sel = 3'd1; cycle();
    ia.load_sel = 3'd3; cycle();
    ia.load = 1'b0;
    check("load.sel", 32'(ia.select), 32'd3);
    repeat (3) cycle();
    check("load.no_tick", 32'(ia.tick), 32'd0);
    cycle();
    check("load.tick_sel", 32'(ia.select), 32'd4);
    check("load.tick", 32'(ia.tick), 32'd1);
    ia.load = 1'b1; ia.load_sel = 3'd6; cycle();
    ia.load = 1'b0;
    check("load.ignored", 32'(ia.select), 32'd4);
    repeat (2) cycle();
    ia.load = 1'b1; ia.load_sel = 3'd2; cycle();
    ia.load = 1'b0;
    check("load.vs_tick_sel", 32'(ia.select), 32'd2);
    check("load.vs_tick_tick", 32'(ia.tick), 32'd0);

    // Asynchronous clear at channel 3.
    ia.load = 1'b1; ia.load_sel = 3'd3; cycle();
    ia.load = 1'b0;
    cycle();
    async_clear(0);
    check("clr.sel", 32'(ia.select), 32'd0);
    repeat (3) cycle();
    check("clr.no_tick", 32'(ia.tick), 32'd0);
    cycle();
    check("clr.first_tick", 32'(ia.tick), 32'd1);
    check("clr.first_sel", 32'(ia.select), 32'd1);

    // Randomized phase for both scanners.
    for (int i = 0; i < 3000; i++) begin
      ia.run = ($urandom_range(0, 9) < 8); ia.dir = 1'($urandom_range(0, 1));
      ia.load = ($urandom_range(0, 15) == 0); ia.load_sel = 3'($urandom_range(0, 7));
      ia.data = 5'($urandom);
      ib.run = ($urandom_range(0, 9) < 8); ib.dir = 1'($urandom_range(0, 1));
      ib.load = ($urandom_range(0, 15) == 0); ib.load_sel = 3'($urandom_range(0, 7));
      ib.data = 8'($urandom);
      if ($urandom_range(0, 299) == 0) async_clear(int'($urandom_range(0, 1)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N-channel scanning multiplexer: a prescaler produces a slow tick from clk, and each tick advances a channel index that selects one data bit.
- Successor to the fixed 8-channel, 1 Hz, ripple-counter scanner.
- Fully synchronous single-clock design; the prescaler produces an enable tick, not a derived clock.
- Adds run/pause, up/down direction, direct channel load, a wrap flag and a 50%-duty slow-phase output; registered outputs throughout.

Parameters:
- CHANNELS, 8: number of data inputs scanned; legal range 2..256.
- SEL_W, 3: width of select; must satisfy 2**SEL_W >= CHANNELS.
- RATE, 50000000: clk cycles per scan step (50 MHz -> 1 Hz); legal range >= 1.
- CNT_W, 26: prescaler width; must satisfy 2**CNT_W > RATE-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous and active-high.
- run  in  1  1 = prescaler counts and scan advances; 0 = pause, all state held.
- dir  in  1  0 = scan up, 1 = scan down; sampled on the tick cycle.
- load  in  1  one-cycle request to jump to load_sel.
- load_sel  in  SEL_W  target channel for load.
- data  in  CHANNELS  data bits; bit i is channel i.
- out  out  1  registered data[select].
- select  out  SEL_W  current channel index.
- tick  out  1  one-clk pulse on each scan step.
- wrap  out  1  one-clk pulse when select wraps around.
- slow  out  1  50%-duty phase: 1 while prescaler < RATE/2 (integer division).

Behaviour:
- Reset (clear=1, asynchronous) values:
  - prescaler = 0, select = 0, out = 0, tick = 0, wrap = 0.
  - slow = 1 if RATE >= 2, else 0.
- Prescaler:
  - When run=1, it counts 0..RATE-1 and returns to 0 after RATE-1.
  - When run=0, it holds its value, and tick/wrap are 0.
- tick: registered 1 in the cycle after the prescaler is at RATE-1 with run=1. Exactly one pulse per RATE running cycles. With RATE=1, tick is held at 1 while run=1.
- Step timing: select updates on the same edge that asserts tick, so the new select is visible while tick=1.
- Step rules:
  - dir=0: select+1; CHANNELS-1 -> 0 asserts wrap.
  - dir=1: select-1; 0 -> CHANNELS-1 asserts wrap.
  - wrap is coincident with tick and never asserts without tick.
- load (synchronous, highest priority):
  - If load=1 and load_sel < CHANNELS: select <= load_sel, prescaler <= 0, tick and wrap forced to 0 that cycle.
  - Load acts regardless of run.
  - If load_sel >= CHANNELS the load is ignored entirely; normal counting proceeds.
- load vs. tick in the same cycle: load wins, and the step is discarded.
- out: registered each clk as data[select] using the select value before the edge, i.e. one clk of latency behind select. out follows data changes even while paused.
- select invariant: never takes a value >= CHANNELS.
- slow: registered from the prescaler value; frozen during pause.
- clear mid-scan: immediate return to reset values. Counting resumes from channel 0 on the first running edge after clear falls.
- Arithmetic: all comparisons unsigned. Counter wrap is explicit (compare-and-reset), not modulo-power-of-two, so non-power-of-two CHANNELS and RATE are exact.

Test Plan:
- Reset and up-scan (CHANNELS=5, RATE=4, run=1, dir=0, data=5'b10110):
  - Ticks every 4 clks; select runs 0,1,2,3,4,0.
  - wrap asserts only on the 4->0 tick.
  - out one clk behind select: 0,1,1,0,1,0.
- Down-scan (same config, dir=1 from select=0):
  - First tick gives select=4 with wrap=1.
  - Then 3,2,1,0 with wrap=0.
- Pause:
  - Drop run for 10 clks at prescaler=2; select, slow and prescaler are frozen, tick=0.
  - After run returns, the next tick arrives after exactly 2 more running clks.
- load:
  - load=1, load_sel=3 while select=1 gives select=3 and prescaler=0; next tick 4 clks later gives select=4.
  - load_sel=6 is ignored, select unchanged.
  - load coincident with tick: select=load_sel, tick=0.
- Async clear mid-scan:
  - Assert clear between edges at select=3; outputs reach reset values immediately, without waiting for a clk edge.
  - After release, the first tick gives select=1.
- RATE=1, CHANNELS=8:
  - tick is constant 1; select increments every clk 0..7 and wraps.
  - slow = 0 throughout.
